mem_bus_bridge: RTL

Responder for the pipeline's data-memory port: accepts the EX/MEM-stage load/store request (read/write strobes, funct3, address, store data) and performs it on a byte-wide req/ack external memory bus. Splits LW/SW into four and LH/SH into two sequential little-endian byte transfers, and sign- or zero-extends load results. Holds the pipeline through a combinational `stall` output until the access completes. Sits between the EX/MEM register and external data memory, in place of a single-cycle memory model.

---
 rtl/rv32_mem_pkg.sv | 69 ++++++
 rtl/mem_load_align.sv | 25 ++
 rtl/mem_bus_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared load/store definitions for the data-memory path.
// Provides funct3 encodings, the bridge FSM state type, the latched request
// payload, and helpers for transfer size and alignment checks.
package rv32_mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned F3_W   = 3;

  // Load encodings
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Request captured from EX/MEM at the start of an access
  typedef struct packed {
    logic              wr;
    logic [F3_W-1:0]   funct3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;

  // Number of byte transfers for a funct3 (1, 2 or 4)
  function automatic logic [2:0] bytes_for_funct3(input logic [F3_W-1:0] f3);
    logic [2:0] n;
    case (f3)
      F3_LH, F3_LHU: n = 3'd2;
      F3_LW:         n = 3'd4;
      default:       n = 3'd1;
    endcase
    return n;
  endfunction

  // funct3 values that name no load/store
  function automatic logic illegal_funct3(input logic [F3_W-1:0] f3);
    logic bad;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment
  function automatic logic misaligned(input logic [F3_W-1:0] f3,
                                      input logic [1:0]      addr_lo);
    logic mis;
    case (f3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load result formatting: takes the little-endian gathered word (byte 0 in
// lane 0) and applies sign or zero extension according to funct3.
// Ports: word (gathered bytes), funct3 (load type), load_data_c (result).
module mem_load_align
  import rv32_mem_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] load_data_c
);

  localparam int unsigned HALF_W = 2 * BYTE_W;

  always_comb begin
    load_data_c = word;
    case (funct3)
      F3_LB:  load_data_c = {{(XLEN - BYTE_W){word[BYTE_W-1]}}, word[BYTE_W-1:0]};
      F3_LBU: load_data_c = {{(XLEN - BYTE_W){1'b0}}, word[BYTE_W-1:0]};
      F3_LH:  load_data_c = {{(XLEN - HALF_W){word[HALF_W-1]}}, word[HALF_W-1:0]};
      F3_LHU: load_data_c = {{(XLEN - HALF_W){1'b0}}, word[HALF_W-1:0]};
      default: load_data_c = word;
    endcase
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Data-memory bridge: performs a pipeline load/store as 1, 2 or 4 sequential
// little-endian byte transfers on a req/ack bus, holding the pipeline via a
// combinational stall until the access finishes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_rd, mem_wr           load / store request (store wins)
//   funct3, addr, wdata      access type, byte address, store data
//   rdata                    registered, extended load result
//   stall                    combinational pipeline hold
//   err                      one-cycle pulse: misaligned, illegal, timeout
//   bus_req/we/addr/wdata    byte-transfer request to memory
//   bus_ack, bus_rdata       memory accept and read byte
module mem_bus_bridge
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [F3_W-1:0]   funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              stall,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [BYTE_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [BYTE_W-1:0] bus_rdata
);

  localparam int unsigned CNT_W = 32;

  state_t             state, state_n;
  mem_req_t           req_q, req_n;
  logic [XLEN-1:0]    idx_q, idx_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [XLEN-1:0]    word_q, word_n;
  logic [XLEN-1:0]    rdata_n;
  logic               err_n;
  logic               bus_req_n;
  logic               bus_we_n;
  logic [XLEN-1:0]    bus_addr_n;
  logic [BYTE_W-1:0]  bus_wdata_n;
  logic [XLEN-1:0]    nbytes_c;
  logic [XLEN-1:0]    load_data_c;
  logic               req_c;

  assign req_c    = mem_rd | mem_wr;
  assign nbytes_c = XLEN'(bytes_for_funct3(req_q.funct3));

  // Pipeline hold: request waiting in IDLE or transfer in progress
  assign stall = ((state == IDLE) & req_c) | (state == XFER);

  mem_load_align u_align (
    .word        (word_q),
    .funct3      (req_q.funct3),
    .load_data_c (load_data_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_n;
      req_q     <= req_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      word_q    <= word_n;
      rdata     <= rdata_n;
      err       <= err_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    req_n   = req_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    word_n  = word_q;
    rdata_n = rdata;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (req_c) begin
          req_n.wr     = mem_wr;
          req_n.funct3 = funct3;
          req_n.addr   = addr;
          req_n.wdata  = wdata;
          idx_n        = '0;
          cnt_n        = '0;
          word_n       = '0;
          // Bad requests skip the bus entirely and just report
          if (illegal_funct3(funct3) || misaligned(funct3, addr[1:0])) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = XFER;
          end
        end
      end

      XFER: begin
        if (bus_ack) begin
          if (!req_q.wr) begin
            word_n[{idx_q[1:0], 3'b000} +: BYTE_W] = bus_rdata;
          end
          idx_n = idx_q + XLEN'(1);
          cnt_n = '0;
          if (idx_q == nbytes_c - XLEN'(1)) begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_n == CNT_W'(TIMEOUT_CYCLES)) begin
            state_n = DONE;
            err_n   = 1'b1;
          end
        end
      end

      DONE: begin
        // err is high only for failed accesses; those leave rdata alone
        if (!req_q.wr && !err) begin
          rdata_n = load_data_c;
        end
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Bus outputs are registered from the upcoming transfer position
    bus_req_n   = (state_n == XFER);
    bus_we_n    = bus_req_n & req_n.wr;
    bus_addr_n  = req_n.addr + idx_n;
    bus_wdata_n = req_n.wdata[{idx_n[1:0], 3'b000} +: BYTE_W];
  end

endmodule
